// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the D-stage instruction and carries control words through EX/MEM/WB,
// generating load-use, flush and mult/div stalls. Define PIPE_CTRL_PERF_EN to add saturating perf counters.
module pipe_ctrl_unit #(
    parameter int         OPC_W     = 5,
    parameter int         REG_W     = 5,
    parameter int         CW        = 14,
    parameter logic [4:0] MUL_ALUOP = 5'b00110,
    parameter logic [4:0] DIV_ALUOP = 5'b00111
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int         CNT_W     = 16
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OPC_W-1:0] opcode_d,
    input  logic [4:0]       aluop_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             branch_taken_ex,
    input  logic             md_rdy,
    output logic [CW-1:0]    ctrl_d,
    output logic [CW-1:0]    ctrl_ex,
    output logic [CW-1:0]    ctrl_mem,
    output logic [CW-1:0]    ctrl_wb,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             md_start,
    output logic             illegal_d
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] md_cnt
`endif
);

    localparam int B_RWE    = 0;
    localparam int B_SW     = 1;
    localparam int B_ALUINB = 2;
    localparam int B_RI     = 3;
    localparam int B_DMWE   = 4;
    localparam int B_LW     = 5;
    localparam int B_JAL    = 6;
    localparam int B_BNE    = 7;
    localparam int B_BLT    = 8;
    localparam int B_BEX    = 9;
    localparam int B_J      = 10;
    localparam int B_JR     = 11;
    localparam int B_SETX   = 12;
    localparam int B_MD     = 13;

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_JR    = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_BLT   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_SETX  = OPC_W'(5'b10101);
    localparam logic [OPC_W-1:0] OP_BEX   = OPC_W'(5'b10110);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t state;
    logic   rtype_d;
    logic   md_hold;
    logic   load_use;
    logic   advance;

    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        case (opcode_d)
            OP_RTYPE: begin
                ctrl_d[B_RWE] = 1'b1;
                ctrl_d[B_MD]  = (aluop_d == MUL_ALUOP) || (aluop_d == DIV_ALUOP);
            end
            OP_ADDI: begin
                ctrl_d[B_RWE] = 1'b1; ctrl_d[B_ALUINB] = 1'b1; ctrl_d[B_RI] = 1'b1;
            end
            OP_LW: begin
                ctrl_d[B_RWE] = 1'b1; ctrl_d[B_ALUINB] = 1'b1; ctrl_d[B_RI] = 1'b1;
                ctrl_d[B_LW]  = 1'b1;
            end
            OP_SW: begin
                ctrl_d[B_SW] = 1'b1; ctrl_d[B_ALUINB] = 1'b1; ctrl_d[B_RI] = 1'b1;
                ctrl_d[B_DMWE] = 1'b1;
            end
            OP_J:    begin ctrl_d[B_RI] = 1'b1; ctrl_d[B_J] = 1'b1; end
            OP_BNE:  begin ctrl_d[B_SW] = 1'b1; ctrl_d[B_RI] = 1'b1; ctrl_d[B_BNE] = 1'b1; end
            OP_JAL: begin
                ctrl_d[B_RWE] = 1'b1; ctrl_d[B_RI] = 1'b1; ctrl_d[B_JAL] = 1'b1;
                ctrl_d[B_J]   = 1'b1;
            end
            OP_JR:   begin ctrl_d[B_SW] = 1'b1; ctrl_d[B_RI] = 1'b1; ctrl_d[B_JR] = 1'b1; end
            OP_BLT:  begin ctrl_d[B_SW] = 1'b1; ctrl_d[B_RI] = 1'b1; ctrl_d[B_BLT] = 1'b1; end
            OP_BEX:  begin ctrl_d[B_RI] = 1'b1; ctrl_d[B_BEX] = 1'b1; end
            OP_SETX: begin ctrl_d[B_RWE] = 1'b1; ctrl_d[B_RI] = 1'b1; ctrl_d[B_SETX] = 1'b1; end
            default: illegal_d = 1'b1;
        endcase
    end

    // MD outranks flush, which outranks load-use; rt only matters when D actually reads it.
    always_comb begin
        rtype_d  = (opcode_d == OP_RTYPE);
        md_hold  = ((state == RUN) && ctrl_ex[B_MD]) || ((state == MD_WAIT) && !md_rdy);
        load_use = ctrl_ex[B_LW] && (rd_ex != '0) &&
                   ((rd_ex == rs_d) || ((rd_ex == rt_d) && (ctrl_d[B_SW] || rtype_d)));
        stall_fd = md_hold || (!branch_taken_ex && load_use);
        flush_fd = !md_hold && branch_taken_ex;
        advance  = !md_hold && !branch_taken_ex && !load_use;
    end

    // md_start is registered one edge early, so it is high exactly while an MD op sits in EX in RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            ctrl_ex  <= '0;
            ctrl_mem <= '0;
            ctrl_wb  <= '0;
            md_start <= 1'b0;
        end else begin
            ctrl_wb  <= ctrl_mem;
            md_start <= advance && ctrl_d[B_MD];
            if (md_hold) begin
                ctrl_mem <= '0;
            end else if (!advance) begin
                ctrl_mem <= ctrl_ex;
                ctrl_ex  <= '0;
            end else begin
                ctrl_mem <= ctrl_ex;
                ctrl_ex  <= ctrl_d;
            end
            case (state)
                RUN:     if (ctrl_ex[B_MD]) state <= MD_WAIT;
                MD_WAIT: if (md_rdy)        state <= RUN;
                default:                    state <= RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            md_cnt    <= '0;
        end else begin
            if (stall_fd && (stall_cnt != '1))           stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_fd && (flush_cnt != '1))           flush_cnt <= flush_cnt + CNT_W'(1);
            if ((state == MD_WAIT) && (md_cnt != '1))    md_cnt    <= md_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural pipeline model.
module tb_pipe_ctrl_unit;

    localparam logic [13:0] RWE = 14'h0001, SWB = 14'h0002, ALUINB = 14'h0004, RI = 14'h0008;
    localparam logic [13:0] DMWE = 14'h0010, LW = 14'h0020, JAL = 14'h0040, BNE = 14'h0080;
    localparam logic [13:0] BLT = 14'h0100, BEX = 14'h0200, JB = 14'h0400, JR = 14'h0800;
    localparam logic [13:0] SETX = 14'h1000, MD = 14'h2000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  opcode_d, aluop_d, rs_d, rt_d, rd_ex;
    logic        branch_taken_ex, md_rdy;
    logic [13:0] ctrl_d, ctrl_ex, ctrl_mem, ctrl_wb;
    logic        stall_fd, flush_fd, md_start, illegal_d;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt, md_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int seen_stalls, seen_starts;

    // Model: the three stage words plus whether a mult/div is outstanding
    logic [13:0] m_ex, m_mem, m_wb;
    bit          m_waiting;

    always #5 clock = ~clock;

    pipe_ctrl_unit dut (
        .clock(clock), .reset_n(reset_n), .opcode_d(opcode_d), .aluop_d(aluop_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_ex(rd_ex), .branch_taken_ex(branch_taken_ex),
        .md_rdy(md_rdy), .ctrl_d(ctrl_d), .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem),
        .ctrl_wb(ctrl_wb), .stall_fd(stall_fd), .flush_fd(flush_fd), .md_start(md_start),
        .illegal_d(illegal_d)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .md_cnt(md_cnt)
`endif
    );

    function automatic logic [13:0] ref_decode(input logic [4:0] op, input logic [4:0] aop);
        case (op)
            5'b00000: return RWE | (((aop == 5'b00110) || (aop == 5'b00111)) ? MD : 14'h0);
            5'b00101: return RWE | ALUINB | RI;
            5'b01000: return RWE | ALUINB | RI | LW;
            5'b00111: return SWB | ALUINB | RI | DMWE;
            5'b00001: return RI | JB;
            5'b00010: return SWB | RI | BNE;
            5'b00011: return RWE | RI | JAL | JB;
            5'b00100: return SWB | RI | JR;
            5'b00110: return SWB | RI | BLT;
            5'b10110: return RI | BEX;
            5'b10101: return RWE | RI | SETX;
            default:  return 14'h0;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00001, 5'b00010,
            5'b00011, 5'b00100, 5'b00110, 5'b10110, 5'b10101: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one D-stage cycle at a negedge, check everything, advance the model, wait for the next negedge.
    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic br,
                                 input logic rdy);
        logic [13:0] exp_d;
        bit md_busy, lu, exp_stall, exp_flush;
        opcode_d = op; aluop_d = aop; rs_d = rs; rt_d = rt; rd_ex = rd;
        branch_taken_ex = br; md_rdy = rdy;
        #1;
        exp_d   = ref_decode(op, aop);
        md_busy = m_waiting ? !rdy : m_ex[13];
        lu      = m_ex[5] && (rd != 0) &&
                  ((rd == rs) || ((rd == rt) && (exp_d[1] || op == 5'b00000)));
        exp_stall = md_busy || (lu && !br);
        exp_flush = br && !md_busy;
        checkOutput("ctrl_d", 32'(ctrl_d), 32'(exp_d));
        checkOutput("illegal_d", 32'(illegal_d), 32'(ref_illegal(op)));
        checkOutput("ctrl_ex", 32'(ctrl_ex), 32'(m_ex));
        checkOutput("ctrl_mem", 32'(ctrl_mem), 32'(m_mem));
        checkOutput("ctrl_wb", 32'(ctrl_wb), 32'(m_wb));
        checkOutput("stall_fd", 32'(stall_fd), 32'(exp_stall));
        checkOutput("flush_fd", 32'(flush_fd), 32'(exp_flush));
        checkOutput("md_start", 32'(md_start), 32'(!m_waiting && m_ex[13]));
        if (stall_fd) seen_stalls++;
        if (md_start) seen_starts++;
        m_wb = m_mem;
        if (md_busy) begin
            m_mem = 14'h0;
            m_waiting = 1'b1;
        end else begin
            m_mem = m_ex;
            m_ex  = (br || lu) ? 14'h0 : exp_d;
            m_waiting = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic reset_model();
        m_ex = 14'h0; m_mem = 14'h0; m_wb = 14'h0; m_waiting = 1'b0;
    endtask

    initial begin
        logic [4:0] ops [13];
        logic [4:0] aops [4];
        ops  = '{5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00001, 5'b00010, 5'b00011,
                 5'b00100, 5'b00110, 5'b10110, 5'b10101, 5'b11111, 5'b01111};
        aops = '{5'b00000, 5'b00001, 5'b00110, 5'b00111};

        reset_n = 1'b0; opcode_d = 5'b00101; aluop_d = '0; rs_d = '0; rt_d = '0; rd_ex = '0;
        branch_taken_ex = 1'b0; md_rdy = 1'b0;
        reset_model();
        repeat (2) @(negedge clock);
        #1;
        checkOutput("reset_ex", 32'(ctrl_ex), 32'h0);
        checkOutput("reset_mem", 32'(ctrl_mem), 32'h0);
        checkOutput("reset_wb", 32'(ctrl_wb), 32'h0);
        checkOutput("reset_stall", 32'(stall_fd), 32'h0);
        checkOutput("reset_md_start", 32'(md_start), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // addi followed by three nops walks 0x00D down the pipe
        applyStimulus(5'b00101, 5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        checkOutput("addi_ex", 32'(ctrl_ex), 32'h00D);
        applyStimulus(5'b00000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("addi_mem", 32'(ctrl_mem), 32'h00D);
        applyStimulus(5'b00000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("addi_wb", 32'(ctrl_wb), 32'h00D);
        applyStimulus(5'b00000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // load-use on r3, then the same shape on r0 which must not stall
        applyStimulus(5'b01000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        seen_stalls = 0;
        applyStimulus(5'b00000, 5'd0, 5'd3, 5'd1, 5'd3, 1'b0, 1'b0);
        checkOutput("lu_bubble", 32'(ctrl_ex), 32'h0);
        applyStimulus(5'b00000, 5'd0, 5'd3, 5'd1, 5'd3, 1'b0, 1'b0);
        checkOutput("lu_add_in_ex", 32'(ctrl_ex), 32'h001);
        checkOutput("lu_stall_cycles", 32'(seen_stalls), 32'd1);
        applyStimulus(5'b01000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        seen_stalls = 0;
        applyStimulus(5'b00000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_r0_no_stall", 32'(seen_stalls), 32'd0);
        checkOutput("lu_r0_add_in_ex", 32'(ctrl_ex), 32'h001);

        // mul in EX, md_rdy arrives after four stalled cycles
        applyStimulus(5'b00000, 5'b00110, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        seen_stalls = 0; seen_starts = 0;
        repeat (4) applyStimulus(5'b00101, 5'd0, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0);
        applyStimulus(5'b00101, 5'd0, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1);
        checkOutput("md_stall_cycles", 32'(seen_stalls), 32'd4);
        checkOutput("md_start_pulses", 32'(seen_starts), 32'd1);
        checkOutput("md_mul_in_mem", 32'(ctrl_mem), 32'h2001);
        checkOutput("md_addi_in_ex", 32'(ctrl_ex), 32'h00D);

        // taken branch beats a simultaneous load-use
        applyStimulus(5'b01000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(5'b00000, 5'd0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0);
        checkOutput("flush_bubble", 32'(ctrl_ex), 32'h0);
        checkOutput("flush_lw_to_mem", 32'(ctrl_mem), 32'h02D);

        // illegal opcode, then asynchronous reset while waiting on a divide
        applyStimulus(5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(5'b00000, 5'b00111, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        reset_model();
        checkOutput("async_rst_ex", 32'(ctrl_ex), 32'h0);
        checkOutput("async_rst_mem", 32'(ctrl_mem), 32'h0);
        checkOutput("async_rst_wb", 32'(ctrl_wb), 32'h0);
        checkOutput("async_rst_md_start", 32'(md_start), 32'h0);
        checkOutput("async_rst_stall", 32'(stall_fd), 32'h0);
        checkOutput("async_rst_flush", 32'(flush_fd), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("post_rst_no_md", 32'(md_start), 32'h0);

        // random traffic, small register range so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            applyStimulus(ops[$urandom_range(0, 12)], aops[$urandom_range(0, 3)],
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
